// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if -- data-memory request/response bus between the MEM pipeline
// stage and the data memory.
//
// Signals:
//   mem_req_o    stage -> mem  request valid (held until acknowledged)
//   mem_we_o     stage -> mem  1 = write, 0 = read (valid with mem_req_o)
//   mem_addr_o   stage -> mem  byte address (valid with mem_req_o)
//   mem_wdata_o  stage -> mem  store data (valid with mem_req_o)
//   mem_ack_i    mem -> stage  one-cycle completion pulse
//   mem_rdata_i  mem -> stage  read data, valid in the mem_ack_i cycle
//
// Modports: master = pipeline stage side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage with a two-state (IDLE/BUSY) data-memory
// handshake and the MEM/WB pipeline register.
//
// A load/store seen in IDLE is captured into request registers and the stage
// moves to BUSY, where mem_req_o is held until mem_ack_i. The upstream pipeline
// is stalled (stall_o, combinational) for every cycle except the completing
// one; each stalled edge inserts a bubble into MEM/WB.
//
// Optional feature (macro MEM_STAGE_TIMEOUT_EN): a BUSY watchdog that abandons
// the access after TIMEOUT_CYCLES unacknowledged cycles, returns 32'hDEADBEEF
// for reads and sets the sticky err_o flag. Without the macro BUSY waits
// indefinitely and err_o is constant 0.
//
// Parameters:
//   TIMEOUT_CYCLES  max BUSY cycles waiting for mem_ack_i (watchdog only)
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   WB_i         writeback controls from EX/MEM
//   M_i          memory controls from EX/MEM; [1]=MemRead, [0]=MemWrite
//   addr_i       ALU result / byte address from EX/MEM
//   data_i       store data from EX/MEM
//   rd_i         destination register from EX/MEM
//   mem_bus      data-memory bus (master side)
//   stall_o      1 = upstream stages must hold
//   WB_o, rdata_o, alu_o, rd_o   MEM/WB register outputs
//   err_o        sticky memory-timeout flag
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  rd_i,
    mem_stage_if.master mem_bus,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_o,
    output logic [4:0]  rd_o,
    output logic        err_o
);

    // The watchdog counter width is derived from TIMEOUT_CYCLES-1.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("mem_stage: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_access;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata_next;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_timeout = (r_state == BUSY) && !mem_bus.mem_ack_i
                       && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_o     = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // M_i = 2'b11 counts as an access; the write bit decides direction.
    assign w_access = (M_i != 2'b00);
    assign w_done   = (r_state == BUSY) && (mem_bus.mem_ack_i || w_timeout);

    always_comb begin
        stall_o = 1'b0;
        if (r_state == IDLE) begin
            stall_o = w_access;
        end else begin
            stall_o = !(mem_bus.mem_ack_i || w_timeout);
        end
    end

    // Read data for the MEM/WB register on a non-stalled edge; writes and
    // non-memory instructions load zero.
    always_comb begin
        w_rdata_next = '0;
        if ((r_state == BUSY) && !r_we) begin
            if (mem_bus.mem_ack_i) begin
                w_rdata_next = mem_bus.mem_rdata_i;
            end else if (w_timeout) begin
                w_rdata_next = 32'hDEAD_BEEF;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            WB_o      <= '0;
            rdata_o   <= '0;
            alu_o     <= '0;
            rd_o      <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            // MEM/WB register: bubble whenever upstream is held.
            if (stall_o) begin
                WB_o    <= '0;
                rdata_o <= '0;
                alu_o   <= '0;
                rd_o    <= '0;
            end else begin
                WB_o    <= WB_i;
                rdata_o <= w_rdata_next;
                alu_o   <= addr_i;
                rd_o    <= rd_i;
            end

            if (r_state == IDLE) begin
                // mem_ack_i is deliberately not looked at here.
                if (w_access) begin
                    r_state   <= BUSY;
                    r_req     <= 1'b1;
                    r_we      <= M_i[0];
                    r_addr    <= addr_i;
                    r_wdata   <= data_i;
`ifdef MEM_STAGE_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
            end else begin
                if (w_done) begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
`endif
            end
        end
    end

    assign mem_bus.mem_req_o   = r_req;
    assign mem_bus.mem_we_o    = r_we;
    assign mem_bus.mem_addr_o  = r_addr;
    assign mem_bus.mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
//
// The bench plays both the upstream pipeline (holding EX/MEM inputs for the
// whole life of an instruction) and the data memory. Each instruction is
// described as a transaction: an access acknowledged d cycles after the
// request starts occupies d+2 cycles, is stalled in all but its last cycle
// and produces one MEM/WB result on its last edge (bubbles before it).
// Build with +define+MEM_STAGE_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int unsigned TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic [1:0]  M_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic [1:0]  WB_o;
    logic [31:0] rdata_o;
    logic [31:0] alu_o;
    logic [4:0]  rd_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    mem_stage_if bus ();

    mem_stage #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .WB_i    (WB_i),
        .M_i     (M_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .rd_i    (rd_i),
        .mem_bus (bus),
        .stall_o (stall_o),
        .WB_o    (WB_o),
        .rdata_o (rdata_o),
        .alu_o   (alu_o),
        .rd_o    (rd_o),
        .err_o   (err_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Expected MEM/WB contents as left by the most recent edge.
    logic [1:0]  exp_wb    = '0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_alu   = '0;
    logic [4:0]  exp_rd    = '0;
    logic        exp_err   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_mwb(input string tag);
        check_val({tag, "_wb"},    32'(WB_o),    32'(exp_wb));
        check_val({tag, "_rdata"}, rdata_o,      exp_rdata);
        check_val({tag, "_alu"},   alu_o,        exp_alu);
        check_val({tag, "_rd"},    32'(rd_o),    32'(exp_rd));
        check_val({tag, "_err"},   32'(err_o),   32'(exp_err));
    endtask

    // One instruction through the stage. d = ack delay after the request
    // starts (d < 0: never acknowledged). stray = pulse mem_ack_i in the
    // first (IDLE) cycle, which the stage must ignore.
    task automatic run_txn(input logic [1:0] wb, input logic [1:0] m,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input int d,
                           input logic [31:0] rdata, input bit stray);
        bit          is_mem = (m != 2'b00);
        bit          is_wr  = m[0];
        bit          tmo    = 1'b0;
        int          last;
        logic [31:0] result;
`ifdef MEM_STAGE_TIMEOUT_EN
        tmo = is_mem && ((d < 0) || (d >= int'(TMO)));
`endif
        if (!is_mem)  last = 0;
        else if (tmo) last = int'(TMO);
        else          last = d + 1;

        if (!is_mem || is_wr) result = 32'h0;
        else if (tmo)         result = 32'hDEAD_BEEF;
        else                  result = rdata;

        for (int k = 0; k <= last; k++) begin
            @(negedge clk_i);
            WB_i   = wb;
            M_i    = m;
            addr_i = addr;
            data_i = data;
            rd_i   = rd;
            if (is_mem && !tmo && (k == last)) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = rdata;
            end else begin
                bus.mem_ack_i   = (k == 0) ? stray : 1'b0;
                bus.mem_rdata_i = $urandom;
            end
            #1;
            check_mwb("mwb");
            check_val("stall", 32'(stall_o), 32'(is_mem && (k < last)));
            check_val("mem_req", 32'(bus.mem_req_o), 32'(is_mem && (k >= 1)));
            if (is_mem && (k >= 1)) begin
                check_val("mem_we",    32'(bus.mem_we_o), 32'(is_wr));
                check_val("mem_addr",  bus.mem_addr_o,    addr);
                check_val("mem_wdata", bus.mem_wdata_o,   data);
            end
            if (k == last) begin
                exp_wb    = wb;
                exp_rdata = result;
                exp_alu   = addr;
                exp_rd    = rd;
                if (tmo) exp_err = 1'b1;
            end else begin
                exp_wb    = '0;
                exp_rdata = '0;
                exp_alu   = '0;
                exp_rd    = '0;
            end
        end
    endtask

    initial begin
        rst_i           = 1'b0;
        WB_i            = '0;
        M_i             = '0;
        addr_i          = '0;
        data_i          = '0;
        rd_i            = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;

        #1;
        check_mwb("reset");
        check_val("reset_req",   32'(bus.mem_req_o), 32'h0);
        check_val("reset_we",    32'(bus.mem_we_o),  32'h0);
        check_val("reset_addr",  bus.mem_addr_o,     32'h0);
        check_val("reset_wdata", bus.mem_wdata_o,    32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Directed: read with late ack, write, non-memory, back-to-back.
        run_txn(2'b11, 2'b10, 32'h0000_0040, 32'h0, 5'd3, 3, 32'h1234_5678, 1'b0);
        run_txn(2'b01, 2'b01, 32'h0000_0080, 32'hCAFE_F00D, 5'd0, 1, 32'h5555_AAAA, 1'b1);
        run_txn(2'b10, 2'b00, 32'h0000_0123, 32'h0BAD_0BAD, 5'd5, 0, 32'h0, 1'b0);
        run_txn(2'b01, 2'b10, 32'h0000_1000, 32'h0, 5'd7, 0, 32'hA5A5_0001, 1'b0);
        run_txn(2'b00, 2'b11, 32'h0000_2000, 32'h7777_8888, 5'd8, 0, 32'hFFFF_FFFF, 1'b0);

        // Reset while BUSY aborts the access; a later stray ack is ignored.
        @(negedge clk_i);
        WB_i          = 2'b11;
        M_i           = 2'b10;
        addr_i        = 32'h0000_0200;
        data_i        = 32'h0;
        rd_i          = 5'd9;
        bus.mem_ack_i = 1'b0;
        #1;
        check_val("abort_stall", 32'(stall_o), 32'h1);
        @(negedge clk_i);
        #1;
        check_val("abort_req_busy", 32'(bus.mem_req_o), 32'h1);
        #2;
        rst_i = 1'b0;
        #1;
        exp_wb    = '0;
        exp_rdata = '0;
        exp_alu   = '0;
        exp_rd    = '0;
        exp_err   = 1'b0;
        check_mwb("abort");
        check_val("abort_req",   32'(bus.mem_req_o), 32'h0);
        check_val("abort_we",    32'(bus.mem_we_o),  32'h0);
        check_val("abort_addr",  bus.mem_addr_o,     32'h0);
        check_val("abort_wdata", bus.mem_wdata_o,    32'h0);
        @(negedge clk_i);
        rst_i  = 1'b1;
        WB_i   = '0;
        M_i    = '0;
        addr_i = '0;
        rd_i   = '0;
        run_txn(2'b10, 2'b00, 32'h0000_0044, 32'h0, 5'd6, 0, 32'h0BAD_CAFE, 1'b1);

        // Randomised instruction stream.
        for (int i = 0; i < 60; i++) begin
            int d;
            d = int'($urandom_range(0, 5));
`ifdef MEM_STAGE_TIMEOUT_EN
            if ($urandom_range(0, 9) == 0) d = -1;
`endif
            run_txn(2'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom),
                    d, $urandom, 1'($urandom));
        end

`ifdef MEM_STAGE_TIMEOUT_EN
        // Unacknowledged read: watchdog fires, err_o stays set afterwards.
        run_txn(2'b01, 2'b10, 32'h0000_0100, 32'h0, 5'd7, -1, 32'h0, 1'b0);
        run_txn(2'b10, 2'b00, 32'h0000_0300, 32'h0, 5'd2, 0, 32'h0, 1'b0);
        run_txn(2'b11, 2'b01, 32'h0000_0400, 32'h1111_2222, 5'd4, 2, 32'h0, 1'b0);
`endif

        // Observe the last transaction's MEM/WB result.
        @(negedge clk_i);
        M_i           = '0;
        bus.mem_ack_i = 1'b0;
        #1;
        check_mwb("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, meaning: max cycles BUSY waits for mem_ack_i (used only with MEM_STAGE_TIMEOUT_EN).
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-low.
REQ-004 WB_i  input  2  writeback controls from EX/MEM register.
REQ-005 M_i  input  2  memory controls from EX/MEM; bit1=MemRead, bit0=MemWrite.
REQ-006 addr_i  input  32  ALU result / memory byte address from EX/MEM.
REQ-007 data_i  input  32  store data from EX/MEM.
REQ-008 rd_i  input  5  destination register from EX/MEM.
REQ-009 mem_req_o  output  1  data-memory request.
REQ-010 mem_we_o  output  1  1=write, 0=read; valid while mem_req_o=1.
REQ-011 mem_addr_o  output  32  request address; valid while mem_req_o=1.
REQ-012 mem_wdata_o  output  32  write data; valid while mem_req_o=1.
REQ-013 mem_ack_i  input  1  memory completion, one-cycle pulse.
REQ-014 mem_rdata_i  input  32  read data, valid in mem_ack_i cycle.
REQ-015 stall_o  output  1  combinational; 1 = upstream (PC, IF/ID, ID/EX, EX/MEM) must hold.
REQ-016 WB_o, rdata_o, alu_o, rd_o  outputs  2/32/32/5  registered MEM/WB stage outputs.
REQ-017 err_o  output  1  sticky memory-timeout flag.

Function
REQ-018 FSM states IDLE, BUSY; reset state IDLE.
REQ-019 Access = M_i != 0; M_i=2'b11 treated as write; rdata_o loads 0 for writes.
REQ-020 IDLE & access: capture addr_i, data_i, write flag into request regs; next state BUSY; stall_o=1 this cycle.
REQ-021 IDLE & no access: stall_o=0; MEM/WB outputs load WB_i, 32'h0 rdata, addr_i, rd_i next edge (latency 1).
REQ-022 BUSY: mem_req_o=1 with captured mem_we_o/mem_addr_o/mem_wdata_o held stable until ack; stall_o = ~mem_ack_i.
REQ-023 BUSY & mem_ack_i: next state IDLE; MEM/WB outputs load WB_i, mem_rdata_i (reads) or 0 (writes), addr_i, rd_i; mem_req_o deasserts next cycle.
REQ-024 Any edge with stall_o=1: MEM/WB outputs load bubble (WB_o=0, rd_o=0, rdata_o=0, alu_o=0).
REQ-025 mem_ack_i in IDLE ignored; no state or output change beyond REQ-021.
REQ-026 Back-to-back accesses: after completion edge the IDLE cycle sees the next EX/MEM access and starts a new request; minimum 2 cycles per access.
REQ-027 mem_req_o=0 in IDLE; mem_req_o never asserted in the capture cycle.

Reset
REQ-028 rst_i=0 forces, asynchronously: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, WB_o=0, rdata_o=0, alu_o=0, rd_o=0, err_o=0, timeout counter 0.
REQ-029 Reset while BUSY aborts the access; a late mem_ack_i after reset release is ignored per REQ-025.

Configuration
REQ-030 Macro MEM_STAGE_TIMEOUT_EN defined: counter clears on IDLE->BUSY and increments each BUSY cycle without ack; at count TIMEOUT_CYCLES-1 without ack, FSM returns IDLE, stall_o=0 that cycle, rdata_o loads 32'hDEADBEEF for reads, err_o sets and holds until reset.
REQ-031 Macro undefined: no counter; BUSY waits indefinitely; err_o tied 0.

Verification
REQ-032 Read: M_i=2'b10, addr_i=0x40, ack 3 cycles after req with rdata 0x12345678 -> stall_o=1 for 4 cycles, rdata_o=0x12345678, alu_o=0x40 after completion edge.
REQ-033 Write: M_i=2'b01, addr_i=0x80, data_i=0xCAFEF00D, ack 1 cycle after req -> mem_we_o=1, mem_wdata_o=0xCAFEF00D stable, rdata_o=0.
REQ-034 Non-memory: M_i=0, WB_i=2'b10, rd_i=5 -> stall_o=0, WB_o=2'b10, rd_o=5 one edge later, mem_req_o stays 0.
REQ-035 Back-to-back read then write, ack immediate -> two requests, each 2 cycles, one bubble between MEM/WB results.
REQ-036 rst_i low in BUSY, then ack pulse after release -> mem_req_o=0 immediately, all outputs 0, stray ack ignored.
REQ-037 MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, read never acked -> after 16 BUSY cycles state IDLE, rdata_o=0xDEADBEEF, err_o=1 sticky.
